fifo_wr_arb: RTL and testbench

//  Round-robin write arbiter sharing one FIFO write port among NumReq requesters.

---
 rtl/fifo_wr_arb.sv | 115 +++++++++++
 tb/tb_fifo_wr_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locking arbiter that shares one FIFO write port among NumReq requesters.
// A winner keeps the port for up to MaxBurst beats, or until it drops valid, then ownership rotates.
module fifo_wr_arb #(
   parameter  int NumReq    = 4,
   parameter  int DataWidth = 8,
   parameter  int MaxBurst  = 4,
   localparam int SrcBits   = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1,
   localparam int CntBits   = $clog2(MaxBurst + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumReq-1:0]           req_valid_i,
   input  logic [NumReq*DataWidth-1:0] req_data_i,
   output logic [NumReq-1:0]           req_ready_o,
   input  logic                        fifo_full_i,
   output logic                        fifo_wr_o,
   output logic [DataWidth-1:0]        fifo_wdata_o,
   output logic [SrcBits-1:0]          fifo_src_o,
   output logic                        busy_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e             r_state,    w_state_nxt;
   logic [SrcBits-1:0] r_owner,    w_owner_nxt;
   logic [SrcBits-1:0] r_rr_ptr,   w_rr_ptr_nxt;
   logic [CntBits-1:0] r_beat_cnt, w_beat_cnt_nxt;

   logic [SrcBits-1:0] w_scan_idx;
   logic [SrcBits-1:0] w_scan_sel;
   logic               w_scan_hit;
   logic [SrcBits-1:0] w_sel;
   logic               w_xfer;

   // NumReq need not be a power of two, so the index wraps by compare rather than overflow.
   function automatic logic [SrcBits-1:0] wrap_inc(input logic [SrcBits-1:0] idx);
      return (idx == SrcBits'(NumReq - 1)) ? '0 : idx + SrcBits'(1);
   endfunction

   // NOTE: blocking assignments here are intentional; the scan index is a loop-carried temporary.
   always_comb begin
      w_scan_hit = 1'b0;
      w_scan_sel = r_rr_ptr;
      w_scan_idx = r_rr_ptr;
      for (int k = 0; k < NumReq; k++) begin
         if (!w_scan_hit && req_valid_i[w_scan_idx]) begin
            w_scan_hit = 1'b1;
            w_scan_sel = w_scan_idx;
         end
         w_scan_idx = wrap_inc(w_scan_idx);
      end
   end

   // With no valid requester the scan falls back to r_rr_ptr, whose valid is 0, so xfer stays low.
   assign w_sel        = (r_state == ST_LOCK) ? r_owner : w_scan_sel;
   assign w_xfer       = req_valid_i[w_sel] & ~fifo_full_i & ~rst_i;

   assign fifo_wr_o    = w_xfer;
   assign req_ready_o  = w_xfer ? (NumReq'(1) << w_sel) : '0;
   assign fifo_wdata_o = req_data_i[w_sel*DataWidth +: DataWidth];
   assign fifo_src_o   = w_sel;
   assign busy_o       = (r_state == ST_LOCK);

   // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               if (MaxBurst == 1) begin
                  w_rr_ptr_nxt = wrap_inc(w_sel);
               end else begin
                  w_state_nxt    = ST_LOCK;
                  w_owner_nxt    = w_sel;
                  w_beat_cnt_nxt = CntBits'(1);
               end
            end
         end
         ST_LOCK: begin
            // A stall (valid with full) matches neither branch and holds the burst untouched.
            if (!req_valid_i[r_owner] ||
                (w_xfer && (r_beat_cnt == CntBits'(MaxBurst - 1)))) begin
               w_state_nxt    = ST_IDLE;
               w_rr_ptr_nxt   = wrap_inc(r_owner);
               w_beat_cnt_nxt = '0;
            end else if (w_xfer) begin
               w_beat_cnt_nxt = r_beat_cnt + CntBits'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments; reset is synchronous and overrides everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: a behavioural model checked every cycle, directed
// scenarios with literal write sequences, and a randomized run with a per-requester scoreboard.
module tb_fifo_wr_arb;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR-1:0]    valid = '0;
   logic [NR*DW-1:0] data = '0;
   logic [NR-1:0]    ready;
   logic             full = 1'b0;
   logic             wr;
   logic [DW-1:0]    wdata;
   logic [1:0]       src;
   logic             busy;

   logic             b_rst = 1'b1;
   logic [2:0]       b_valid = 3'b111;
   logic [3*DW-1:0]  b_data = {8'hB2, 8'hB1, 8'hB0};
   logic [2:0]       b_ready;
   logic             b_full = 1'b0;
   logic             b_wr;
   logic [DW-1:0]    b_wdata;
   logic [1:0]       b_src;
   logic             b_busy;

   always #5 clk = ~clk;

   fifo_wr_arb #(.NumReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
      .req_ready_o(ready), .fifo_full_i(full), .fifo_wr_o(wr),
      .fifo_wdata_o(wdata), .fifo_src_o(src), .busy_o(busy)
   );

   fifo_wr_arb #(.NumReq(3), .DataWidth(DW), .MaxBurst(1)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .req_valid_i(b_valid), .req_data_i(b_data),
      .req_ready_o(b_ready), .fifo_full_i(b_full), .fifo_wr_o(b_wr),
      .fifo_wdata_o(b_wdata), .fifo_src_o(b_src), .busy_o(b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference state: whether a burst is held, by whom, how many beats, and the rotation start.
   bit            chk_en  = 1'b0;
   bit            t6_mode = 1'b0;
   bit            m_locked = 1'b0;
   int            m_owner = 0;
   int            m_ptr   = 0;
   int            m_beats = 0;
   bit            m_found;
   int            m_sel;
   bit            m_xfer;
   logic [NR-1:0] m_ready;
   logic [NR-1:0] last_acc = '0;
   int            cnt[NR];
   int            sb_next[NR];
   logic [7:0]    base[NR];
   int            wlog[$];
   int            blog[$];

   always @(negedge clk) begin
      if (chk_en) begin
         m_found = 1'b0;
         m_sel   = 0;
         if (m_locked) begin
            m_found = 1'b1;
            m_sel   = m_owner;
         end else begin
            for (int k = 0; k < NR; k++) begin
               if (!m_found && valid[(m_ptr + k) % NR]) begin
                  m_found = 1'b1;
                  m_sel   = (m_ptr + k) % NR;
               end
            end
         end
         m_xfer  = m_found && valid[m_sel] && !full && !rst;
         m_ready = m_xfer ? NR'(1 << m_sel) : '0;

         check("wr", wr, m_xfer);
         check("ready", ready, m_ready);
         check("busy", busy, m_locked);
         if (m_xfer) begin
            check("wdata", wdata, data[m_sel*DW +: DW]);
            check("src", src, m_sel);
         end
         if (wr) begin
            wlog.push_back(int'(src) * 256 + int'(wdata));
            if (t6_mode) begin
               check("t6_order", wdata, {src, 6'(sb_next[src])});
               sb_next[src]++;
            end
         end
         if (t6_mode) check("t6_no_wr_full", wr & full, 0);
         last_acc = m_ready;

         if (rst) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
         end else if (!m_locked) begin
            if (m_xfer) begin
               if (MB == 1) begin
                  m_ptr = (m_sel + 1) % NR;
               end else begin
                  m_locked = 1'b1; m_owner = m_sel; m_beats = 1;
               end
            end
         end else if (!valid[m_owner]) begin
            m_locked = 1'b0; m_ptr = (m_owner + 1) % NR; m_beats = 0;
         end else if (m_xfer) begin
            m_beats++;
            if (m_beats == MB) begin
               m_locked = 1'b0; m_ptr = (m_owner + 1) % NR; m_beats = 0;
            end
         end
      end
      if (b_wr) blog.push_back(int'(b_src) * 256 + int'(b_wdata));
   end

   task automatic set_data();
      for (int i = 0; i < NR; i++) begin
         logic [1:0] id;
         id = 2'(i);
         data[i*DW +: DW] = t6_mode ? {id, 6'(cnt[i])} : 8'(base[i] + 8'(cnt[i]));
      end
   endtask

   // Advance one clock; a requester whose beat was accepted moves on to its next data word.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (last_acc[i]) cnt[i]++;
      set_data();
   endtask

   task automatic reset_a();
      rst   = 1'b1;
      valid = '0;
      full  = 1'b0;
      step();
      step();
      for (int i = 0; i < NR; i++) begin
         cnt[i]  = 0;
         base[i] = 8'h00;
      end
      set_data();
      rst = 1'b0;
      wlog.delete();
   endtask

   int exp_t2[10] = '{'h0A0, 'h0A1, 'h0A2, 'h0A3, 'h2C0, 'h2C1, 'h2C2, 'h2C3, 'h0A4, 'h0A5};
   int exp_t3[3]  = '{'h110, 'h111, 'h330};
   int exp_t4[5]  = '{'h040, 'h041, 'h042, 'h043, 'h150};
   int exp_t5[6]  = '{'h0B0, 'h1B1, 'h2B2, 'h0B0, 'h1B1, 'h2B2};

   initial begin
      step();
      chk_en = 1'b1;

      // T1: reset state, then reset asserted in the middle of a burst
      reset_a();
      #1;
      check("t1_wr_idle", wr, 0);
      check("t1_ready_idle", ready, 0);
      check("t1_busy_idle", busy, 0);
      valid = 4'b0001;
      #1;
      check("t1_wr_first", wr, 1);
      for (int c = 0; c < 5; c++) step();
      check("t1_busy_lock", busy, 1);
      check("t1_ptr_before", dut_a.r_rr_ptr, 1);
      rst = 1'b1;
      #1;
      check("t1_wr_in_rst", wr, 0);
      check("t1_ready_in_rst", ready, 0);
      step();
      rst   = 1'b0;
      valid = '0;
      #1;
      check("t1_busy_after", busy, 0);
      check("t1_ptr_after", dut_a.r_rr_ptr, 0);
      check("t1_cnt_after", dut_a.r_beat_cnt, 0);

      // T2: two always-valid requesters, bursts of four then rotation
      reset_a();
      base[0] = 8'hA0;
      base[2] = 8'hC0;
      set_data();
      valid = 4'b0101;
      for (int c = 0; c < 40 && wlog.size() < 10; c++) step();
      valid = '0;
      check("t2_len", wlog.size(), 10);
      for (int i = 0; i < 10; i++) check($sformatf("t2_beat%0d", i), wlog[i], exp_t2[i]);

      // T3: owner drops valid after two beats, next scan starts after it
      reset_a();
      base[1] = 8'h10;
      base[3] = 8'h30;
      set_data();
      valid = 4'b1010;
      for (int c = 0; c < 20 && cnt[1] < 2; c++) step();
      valid[1] = 1'b0;
      #1;
      check("t3_wr_release", wr, 0);
      check("t3_busy_release", busy, 1);
      step();
      #1;
      check("t3_ptr", dut_a.r_rr_ptr, 2);
      check("t3_wr_next", wr, 1);
      check("t3_src_next", src, 3);
      step();
      valid = '0;
      check("t3_len", wlog.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("t3_beat%0d", i), wlog[i], exp_t3[i]);

      // T4: FIFO full stalls a burst without counting beats or releasing
      reset_a();
      base[0] = 8'h40;
      base[1] = 8'h50;
      set_data();
      valid = 4'b0011;
      for (int c = 0; c < 20 && cnt[0] < 2; c++) step();
      full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t4_wr_stall", wr, 0);
         check("t4_ready_stall", ready, 0);
         check("t4_busy_stall", busy, 1);
         check("t4_cnt_stall", dut_a.r_beat_cnt, 2);
         step();
      end
      full = 1'b0;
      for (int c = 0; c < 20 && wlog.size() < 5; c++) step();
      valid = '0;
      check("t4_len", wlog.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("t4_beat%0d", i), wlog[i], exp_t4[i]);

      // T5: three requesters, per-beat rotation with wrap from 2 to 0
      blog.delete();
      b_rst = 1'b0;
      for (int c = 0; c < 20 && blog.size() < 6; c++) step();
      check("t5_busy", b_busy, 0);
      b_valid = '0;
      check("t5_len", blog.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t5_beat%0d", i), blog[i], exp_t5[i]);

      // T6: random valid/full/reset with valid-hold honoured, per-requester ordering scoreboard
      reset_a();
      t6_mode = 1'b1;
      for (int i = 0; i < NR; i++) sb_next[i] = 0;
      set_data();
      for (int c = 0; c < 3000; c++) begin
         step();
         full = ($urandom_range(3) == 0);
         rst  = ($urandom_range(199) == 0);
         for (int i = 0; i < NR; i++) begin
            if (!(valid[i] && !last_acc[i])) valid[i] = 1'($urandom_range(1));
         end
      end
      valid = '0;
      full  = 1'b0;
      rst   = 1'b0;
      step();
      step();
      for (int i = 0; i < NR; i++) check($sformatf("t6_count%0d", i), sb_next[i], cnt[i]);
      t6_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
